// File: rtl/bbcdr_loop_filter.sv
// Bang-bang CDR digital loop filter.
// Votes from the phase detector are summed over a window of DECIM cycles.
// The sign of each window drives a proportional-plus-integral update of a
// phase accumulator, whose upper bits form the phase-interpolator code.
// A saturating counter of alternating decisions provides a lock indicator.
module bbcdr_loop_filter #(
    parameter int DECIM     = 8,
    parameter int PI_BITS   = 7,
    parameter int FRAC_BITS = 8,
    parameter int INT_BITS  = 12,
    parameter int KP        = 16,
    parameter int KI        = 1,
    parameter int LOCK_CNT  = 16,
    parameter int INIT_CODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up,
    input  logic                       dn,
    input  logic                       freeze,
    output logic [PI_BITS-1:0]         pi_code,
    output logic                       upd,
    output logic signed [INT_BITS-1:0] integ,
    output logic [1:0]                 dec,
    output logic                       lock
);

    localparam int PH_W  = PI_BITS + FRAC_BITS;
    localparam int CNT_W = $clog2(DECIM);
    localparam int SUM_W = $clog2(DECIM + 1) + 1;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    // Wide enough to hold integ plus any 32-bit gain step without overflow.
    localparam int IS_W  = INT_BITS + 33;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(LOCK_CNT);

    // Symmetric integral limits: the most negative code is never used.
    localparam longint                      INT_MAX_L = (longint'(1) <<< (INT_BITS - 1)) - 1;
    localparam logic signed [INT_BITS-1:0]  INT_HI    = INT_BITS'(INT_MAX_L);
    localparam logic signed [INT_BITS-1:0]  INT_LO    = -INT_HI;
    localparam logic signed [IS_W-1:0]      SAT_HI    = IS_W'(INT_MAX_L);
    localparam logic signed [IS_W-1:0]      SAT_LO    = -SAT_HI;

    localparam logic [PH_W-1:0] PHASE_INIT = {PI_BITS'(INIT_CODE), FRAC_BITS'(0)};

    // Direction of the most recent nonzero decision.
    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_POS,
        DIR_NEG
    } dir_t;

    // Window state
    logic [CNT_W-1:0]         cnt;
    logic signed [SUM_W-1:0]  win_sum;
    logic signed [SUM_W-1:0]  win_total;
    logic signed [1:0]        vote;
    logic signed [1:0]        dsgn;
    logic                     win_end;

    // Loop filter datapath
    logic signed [IS_W-1:0]     ki_term;
    logic signed [IS_W-1:0]     integ_sum;
    logic signed [INT_BITS-1:0] integ_new;
    logic [PH_W-1:0]            phase;
    logic [PH_W-1:0]            kp_term;
    logic [PH_W-1:0]            integ_ext;
    logic [PH_W-1:0]            phase_next;

    // Lock tracking
    logic [LCK_W-1:0] lock_cnt;
    logic [LCK_W-1:0] lock_cnt_next;
    dir_t             last_dir;
    dir_t             last_dir_next;
    dir_t             this_dir;

    // Vote for this cycle from the early/late detector pair
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        vote = 2'sb00;
        case ({up, dn})
            2'b10:   vote = 2'sb01;
            2'b01:   vote = 2'sb11;
            default: vote = 2'sb00;
        endcase
    end

    // Window total including the current vote, and its sign as the decision
    always_comb begin
        win_total = win_sum + SUM_W'(vote);
        win_end   = (cnt == CNT_LAST) && !freeze;
        if (win_total == '0) begin
            dsgn = 2'sb00;
        end else if (win_total[SUM_W-1]) begin
            dsgn = 2'sb11;
        end else begin
            dsgn = 2'sb01;
        end
    end

    // Saturating integral update and the resulting modular phase step
    always_comb begin
        ki_term = '0;
        kp_term = '0;
        case (dsgn)
            2'sb01: begin
                ki_term = IS_W'(KI);
                kp_term = PH_W'(KP);
            end
            2'sb11: begin
                ki_term = -IS_W'(KI);
                kp_term = -PH_W'(KP);
            end
            default: begin
                ki_term = '0;
                kp_term = '0;
            end
        endcase

        integ_sum = IS_W'(integ) + ki_term;
        if (integ_sum > SAT_HI) begin
            integ_new = INT_HI;
        end else if (integ_sum < SAT_LO) begin
            integ_new = INT_LO;
        end else begin
            integ_new = INT_BITS'(integ_sum);
        end

        // Sign-extend the new integral; the sum wraps freely in both directions.
        integ_ext  = PH_W'(integ_new);
        phase_next = phase + kp_term + integ_ext;
    end

    // Alternation counting: opposite sign advances, same sign restarts, zero holds
    always_comb begin
        lock_cnt_next = lock_cnt;
        last_dir_next = last_dir;
        this_dir      = (dsgn == 2'sb01) ? DIR_POS : DIR_NEG;
        if (dsgn != 2'sb00) begin
            last_dir_next = this_dir;
            if (last_dir == this_dir) begin
                lock_cnt_next = '0;
            end else if (last_dir != DIR_NONE && lock_cnt != LCK_MAX) begin
                lock_cnt_next = lock_cnt + LCK_W'(1);
            end
        end
    end

    // Vote window: count cycles and accumulate votes, restarting at each window end
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
        if (rst) begin
            cnt     <= '0;
            win_sum <= '0;
        end else if (!freeze) begin
            if (cnt == CNT_LAST) begin
                cnt     <= '0;
                win_sum <= '0;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                win_sum <= win_total;
            end
        end
    end

    // Loop filter state: integral, phase and the registered decision outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            integ <= '0;
            phase <= PHASE_INIT;
            upd   <= 1'b0;
            dec   <= 2'b00;
        end else begin
            upd <= win_end;
            if (win_end) begin
                integ <= integ_new;
                phase <= phase_next;
                dec   <= dsgn;
            end
        end
    end

    // Lock indicator: registered compare of the alternation count with its cap
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
            last_dir <= DIR_NONE;
            lock     <= 1'b0;
        end else if (win_end) begin
            lock_cnt <= lock_cnt_next;
            last_dir <= last_dir_next;
            lock     <= (lock_cnt_next == LCK_MAX);
        end
    end

    assign pi_code = phase[PH_W-1:FRAC_BITS];

endmodule

// File: tb/tb_bbcdr_loop_filter.sv
// Self-checking bench for bbcdr_loop_filter (default parameters).
// Stimulus drives inputs on the falling edge and feeds a window-level
// reference model; each completed window pushes its expected outputs,
// tagged with the clock edge at which they must appear, into a queue.
// A monitor pops and compares whenever upd is due or seen.
module tb_bbcdr_loop_filter;

    localparam int DECIM     = 8;
    localparam int PI_BITS   = 7;
    localparam int FRAC_BITS = 8;
    localparam int INT_BITS  = 12;
    localparam int KP        = 16;
    localparam int KI        = 1;
    localparam int LOCK_CNT  = 16;
    localparam int INIT_CODE = 0;
    localparam int PH_W      = PI_BITS + FRAC_BITS;
    localparam int PH_MOD    = 1 << PH_W;
    localparam int INT_MAX   = (1 << (INT_BITS - 1)) - 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       up;
    logic                       dn;
    logic                       freeze;
    logic [PI_BITS-1:0]         pi_code;
    logic                       upd;
    logic signed [INT_BITS-1:0] integ;
    logic [1:0]                 dec;
    logic                       lock;

    bbcdr_loop_filter #(
        .DECIM(DECIM), .PI_BITS(PI_BITS), .FRAC_BITS(FRAC_BITS), .INT_BITS(INT_BITS),
        .KP(KP), .KI(KI), .LOCK_CNT(LOCK_CNT), .INIT_CODE(INIT_CODE)
    ) dut (
        .clk(clk), .rst(rst), .up(up), .dn(dn), .freeze(freeze),
        .pi_code(pi_code), .upd(upd), .integ(integ), .dec(dec), .lock(lock)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs of one completed window
    typedef struct {
        int edge_no;
        int pi;
        int integ;
        int dec;
        int lock;
        int phase;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state, kept at window granularity
    int m_integ;
    int m_phase;
    int m_lock_cnt;
    int m_last;
    int win_q[$];

    task automatic model_reset();
        m_integ    = 0;
        m_phase    = INIT_CODE << FRAC_BITS;
        m_lock_cnt = 0;
        m_last     = 0;
        win_q.delete();
    endtask

    task automatic model_step(input bit u, input bit d_, input bit f, input bit r);
        int   v;
        int   s;
        int   d;
        exp_t e;
        if (r) begin
            model_reset();
            return;
        end
        if (f) return;
        v = (u && !d_) ? 1 : ((d_ && !u) ? -1 : 0);
        win_q.push_back(v);
        if (win_q.size() == DECIM) begin
            s = win_q.sum();
            d = (s > 0) ? 1 : ((s < 0) ? -1 : 0);
            win_q.delete();
            m_integ = m_integ + KI * d;
            if (m_integ > INT_MAX)  m_integ = INT_MAX;
            if (m_integ < -INT_MAX) m_integ = -INT_MAX;
            m_phase = ((m_phase + KP * d + m_integ) % PH_MOD + PH_MOD) % PH_MOD;
            if (d != 0) begin
                if (m_last == d) m_lock_cnt = 0;
                else if (m_last != 0 && m_lock_cnt < LOCK_CNT) m_lock_cnt++;
                m_last = d;
            end
            e.edge_no = cyc + 1;
            e.pi      = m_phase >> FRAC_BITS;
            e.integ   = m_integ;
            e.dec     = d & 3;
            e.lock    = (m_lock_cnt == LOCK_CNT) ? 1 : 0;
            e.phase   = m_phase;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare a due window result, otherwise upd must be low
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
            mon_e = exp_q.pop_front();
            check("upd", upd, 1);
            check("pi_code", pi_code, mon_e.pi);
            check("integ", integ, mon_e.integ);
            check("dec", dec, mon_e.dec);
            check("lock", lock, mon_e.lock);
            check("phase", dut.phase, mon_e.phase);
        end else begin
            check("upd_idle", upd, 0);
        end
    end

    // One clock of stimulus: drive, inform the model, wait for the edge to pass
    task automatic cycle(input bit u, input bit d_, input bit f, input bit r);
        up     = u;
        dn     = d_;
        freeze = f;
        rst    = r;
        model_step(u, d_, f, r);
        @(negedge clk);
    endtask

    task automatic window(input bit u, input bit d_, input int n);
        repeat (n * DECIM) cycle(u, d_, 1'b0, 1'b0);
    endtask

    task automatic chk_reset();
        check("rst_pi_code", pi_code, INIT_CODE);
        check("rst_integ", integ, 0);
        check("rst_upd", upd, 0);
        check("rst_dec", dec, 0);
        check("rst_lock", lock, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            chk_reset();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int prev_pi;
    int wrap_seen;
    int min_integ;

    initial begin
        up = 1'b0; dn = 1'b0; freeze = 1'b0; rst = 1'b1;
        model_reset();
        @(negedge clk);

        // Reset held for several cycles with random inputs
        do_reset(3);

        // Constant up: first window, then sixteen in total
        repeat (DECIM) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("w1_upd", upd, 1);
        check("w1_dec", dec, 1);
        check("w1_integ", integ, 1);
        check("w1_phase", dut.phase, 17);
        check("w1_pi", pi_code, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("w1_upd_one_cycle", upd, 0);
        repeat (DECIM - 1) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        window(1'b1, 1'b0, 14);
        check("w16_integ", integ, 16);
        check("w16_phase", dut.phase, 392);
        check("w16_pi", pi_code, 1);

        // Tie window and null window
        repeat (DECIM / 2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (DECIM / 2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("tie_dec", dec, 0);
        check("tie_integ", integ, 16);
        check("tie_phase", dut.phase, 408);
        window(1'b1, 1'b1, 1);
        check("null_dec", dec, 0);
        check("null_phase", dut.phase, 424);

        // Random votes with occasional freeze and reset
        for (int i = 0; i < 600; i++) begin
            bit u, d_, f, r;
            u  = 1'($urandom_range(0, 1));
            d_ = 1'($urandom_range(0, 1));
            f  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 199) == 0);
            cycle(u, d_, f, r);
            if (r) chk_reset();
        end

        // Freeze for five cycles mid-window; frozen dn votes must be ignored
        do_reset(1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("frz_no_early_upd", upd, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("frz_upd_delayed", upd, 1);
        check("frz_dec", dec, 1);
        check("frz_integ", integ, 1);

        // Reset after four cycles of a window discards the partial sum
        do_reset(1);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        do_reset(1);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("mrst_no_early_upd", upd, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("mrst_upd", upd, 1);
        check("mrst_dec", dec, 1);

        // Lock: sixteen alternations, zero window, then a repeated sign
        do_reset(1);
        for (int w = 0; w <= LOCK_CNT; w++) begin
            if (w % 2 == 0) window(1'b1, 1'b0, 1);
            else            window(1'b0, 1'b1, 1);
            check("lock_progress", lock, (w == LOCK_CNT) ? 1 : 0);
        end
        repeat (DECIM / 2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (DECIM / 2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("lock_zero_window", lock, 1);
        window(1'b0, 1'b1, 1);
        check("lock_still_alt", lock, 1);
        window(1'b0, 1'b1, 1);
        check("lock_same_sign", lock, 0);

        // Constant up: integral saturation and upward code wrap
        do_reset(1);
        prev_pi   = pi_code;
        wrap_seen = 0;
        for (int w = 0; w < 2100; w++) begin
            window(1'b1, 1'b0, 1);
            if (prev_pi == 127 && pi_code == 0) wrap_seen = 1;
            prev_pi = pi_code;
        end
        check("sat_hi_integ", integ, INT_MAX);
        check("wrap_up_seen", wrap_seen, 1);

        // Constant dn: downward code wrap and negative saturation
        do_reset(1);
        window(1'b0, 1'b1, 1);
        check("wrap_dn_pi", pi_code, 127);
        check("wrap_dn_phase", dut.phase, 32751);
        min_integ = 0;
        for (int w = 0; w < 2100; w++) begin
            window(1'b0, 1'b1, 1);
            if (int'(integ) < min_integ) min_integ = integ;
        end
        check("sat_lo_integ", integ, -INT_MAX);
        check("sat_lo_min", min_integ, -INT_MAX);

        // Drain and confirm every expected window was presented
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bbcdr_loop_filter.md
BBCDR_LOOP_FILTER -- requirements
Module: bbcdr_loop_filter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DECIM, 8: vote window length in cycles, at least 2.
- PI_BITS, 7: phase-interpolator code width.
- FRAC_BITS, 8: fractional bits of the phase accumulator.
- INT_BITS, 12: integral register width (signed), at most PI_BITS+FRAC_BITS.
- KP, 16: proportional gain, in phase-accumulator LSBs.
- KI, 1: integral gain, in integral LSBs.
- LOCK_CNT, 16: number of alternations required to declare lock.
- INIT_CODE, 0: pi_code value after reset.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on its rising edge.
- rst, in, 1: reset; synchronous, active-high.
- up, in, 1: early indication from the bang-bang phase detector.
- dn, in, 1: late indication from the bang-bang phase detector.
- freeze, in, 1: hold all loop state.
- pi_code, out, PI_BITS: phase-interpolator code.
- upd, out, 1: one-cycle pulse, high when a new pi_code is visible.
- integ, out, INT_BITS: integral register, signed two's complement.
- dec, out, 2: last window decision. 01 = +1, 11 = -1, 00 = 0.
- lock, out, 1: lock indicator.

Function
REQ-003 Each non-frozen cycle SHALL produce a vote v:
- +1 for up=1, dn=0.
- -1 for up=0, dn=1.
- 0 for up=dn (both high or both low).

REQ-004 The block SHALL accumulate votes in a signed window sum and count cycles in a window counter 0..DECIM-1.
- The counter wraps to 0 after DECIM-1.

REQ-005 On the window-end cycle (counter = DECIM-1, not frozen), the decision d SHALL be the sign of (sum + v): +1, -1 or 0.
- The window sum SHALL clear to 0 at that same edge.
- The current vote SHALL be included in d, not carried into the next window.

REQ-006 At the window-end edge, the integral SHALL update as integ <= sat(integ + KI*d).
- Saturation is symmetric at +/-(2^(INT_BITS-1)-1).
- The integral never reaches -2^(INT_BITS-1).

REQ-007 At the same edge, the phase accumulator SHALL update as phase <= phase + KP*d + integ_new.
- phase is unsigned, PI_BITS+FRAC_BITS wide.
- integ_new is the saturated value from REQ-006, sign-extended.
- Arithmetic is modulo 2^(PI_BITS+FRAC_BITS), so pi_code wraps in both directions with no saturation.

REQ-008 pi_code SHALL equal phase[PI_BITS+FRAC_BITS-1:FRAC_BITS].

REQ-009 upd and dec SHALL be registered at the window-end edge.
- upd is high for exactly the one cycle following the edge.
- Latency: the vote on the window-end cycle affects pi_code, integ and dec after one edge.

REQ-010 freeze=1 SHALL hold all state (window sum, counter, integ, phase, lock count) and SHALL force upd=0.
- Votes arriving while frozen are discarded.
- The window resumes from the held count when freeze deasserts.

REQ-011 Lock tracking SHALL use a saturating counter, capped at LOCK_CNT:
- Increment when d is nonzero and opposite in sign to the last nonzero d.
- Clear to 0 when d is nonzero and equal in sign to the last nonzero d.
- Leave unchanged when d = 0.

REQ-012 lock SHALL be 1 exactly when the lock counter equals LOCK_CNT.

REQ-013 When the integral is at saturation, a further same-sign decision SHALL leave integ unchanged.
- The phase update in that case still applies KP*d + integ.

Reset
REQ-014 rst=1 at a clock edge SHALL set the following, with priority over freeze and over any window-end update:
- window sum = 0, counter = 0.
- integ = 0.
- phase = INIT_CODE << FRAC_BITS.
- upd = 0, dec = 00, lock = 0, lock counter = 0.
- last nonzero d = none.

REQ-015 A reset mid-window SHALL discard the partial window sum.
- The first window after reset is a full DECIM cycles.

Verification
REQ-016 The bench SHALL cover reset: after rst, expect pi_code=0, integ=0, upd=0, dec=00, lock=0, held while rst=1.

REQ-017 The bench SHALL cover a constant up stream, defaults:
- After window 1: upd pulse in cycle 9, dec=01, integ=1, phase=17, pi_code=0.
- After 16 windows: integ=16, phase=392, pi_code=1.

REQ-018 The bench SHALL cover tie and null windows:
- A window of 4 up then 4 dn gives d=0 and integ unchanged; phase advances by integ only.
- A window with up=dn=1 throughout gives d=0.

REQ-019 The bench SHALL cover saturation and wrap:
- Constant up for more than 2047 windows holds integ at 2047.
- pi_code wraps 127 -> 0.
- A constant dn stream wraps pi_code 0 -> 127.

REQ-020 The bench SHALL cover freeze and mid-window reset:
- freeze for 5 cycles mid-window: the window end is delayed by exactly 5 cycles, votes during freeze are ignored, and upd=0.
- rst at cycle 4 of a window clears the partial sum.

REQ-021 The bench SHALL cover lock:
- Windows alternating up/dn: lock=1 after the decision that makes 16 alternations.
- Two consecutive same-sign decisions then give lock=0.
- An interleaved d=0 window does not clear lock.
